// File: rtl/prime_entry_ctrl_if.sv
// prime_entry_ctrl_if: board-side bundle for the prime-entry sequencer.
// master = board/testbench side, slave = controller side.
interface prime_entry_ctrl_if #(
  parameter int WIDTH = 10
);
  logic             key_n;
  logic [WIDTH-1:0] sw;
  logic             is_prime;
  logic [WIDTH-1:0] prime0;
  logic [WIDTH-1:0] prime1;
  logic [1:0]       state;
  logic             pair_valid;
  logic             reject;
  logic [WIDTH-1:0] show_value;
  logic             press_led;

  modport master (
    output key_n,
    output sw,
    output is_prime,
    input  prime0,
    input  prime1,
    input  state,
    input  pair_valid,
    input  reject,
    input  show_value,
    input  press_led
  );

  modport slave (
    input  key_n,
    input  sw,
    input  is_prime,
    output prime0,
    output prime1,
    output state,
    output pair_valid,
    output reject,
    output show_value,
    output press_led
  );
endinterface

// File: rtl/prime_entry_ctrl.sv
// prime_entry_ctrl: debounced button, prime capture and review FSM.
// Define DISTINCT_CHECK_EN to reject a second prime equal to the first.
module prime_entry_ctrl #(
  parameter int WIDTH     = 10,
  parameter int DB_CYCLES = 250000,
  parameter int DB_CNT_W  = 18
) (
  input logic               clk,
  input logic               rst_n,
  prime_entry_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    S_GET0  = 2'd0,
    S_GET1  = 2'd1,
    S_SHOW0 = 2'd2,
    S_SHOW1 = 2'd3
  } state_t;

  localparam logic [DB_CNT_W-1:0] DB_MAX =
    DB_CNT_W'(DB_CYCLES - 1);

  logic                key_s1;
  logic                key_s2;
  logic                db_level;
  logic [DB_CNT_W-1:0] db_cnt;
  logic                press;
  logic [1:0]          warm;
  logic                armed;
  logic                accept1;

  state_t              state_q;
  logic [WIDTH-1:0]    prime0_q;
  logic [WIDTH-1:0]    prime1_q;
  logic                pair_q;
  logic                reject_q;
  logic [WIDTH-1:0]    show_q;

  // two-flop synchroniser, idles released
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      key_s1 <= 1'b1;
      key_s2 <= 1'b1;
    end else begin
      key_s1 <= bus.key_n;
      key_s2 <= key_s1;
    end
  end

  // arm presses only once a released level is seen after reset,
  // so a button held through reset cannot fire
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      warm  <= 2'd0;
      armed <= 1'b0;
    end else begin
      if (warm != 2'd2)
        warm <= warm + 2'd1;
      if (warm == 2'd2 && key_s2 && db_level)
        armed <= 1'b1;
    end
  end

  // debounce counter and one-cycle press pulse on debounced fall
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      db_level <= 1'b1;
      db_cnt   <= '0;
      press    <= 1'b0;
    end else begin
      press <= 1'b0;
      if (key_s2 != db_level) begin
        if (db_cnt == DB_MAX) begin
          db_level <= key_s2;
          db_cnt   <= '0;
          press    <= armed & ~key_s2;
        end else begin
          db_cnt <= db_cnt + 1'b1;
        end
      end else begin
        db_cnt <= '0;
      end
    end
  end

  // second-prime acceptance, optionally demanding a distinct value
  always_comb begin
    accept1 = bus.is_prime;
`ifdef DISTINCT_CHECK_EN
    accept1 = bus.is_prime && (bus.sw != prime0_q);
`else
    accept1 = bus.is_prime;
`endif
  end

  // entry/review FSM with registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_GET0;
      prime0_q <= '0;
      prime1_q <= '0;
      pair_q   <= 1'b0;
      reject_q <= 1'b0;
      show_q   <= '0;
    end else begin
      unique case (state_q)
        S_GET0:  show_q <= bus.sw;
        S_GET1:  show_q <= bus.sw;
        S_SHOW0: show_q <= prime0_q;
        S_SHOW1: show_q <= prime1_q;
      endcase
      if (press) begin
        unique case (state_q)
          S_GET0: begin
            if (bus.is_prime) begin
              prime0_q <= bus.sw;
              reject_q <= 1'b0;
              state_q  <= S_GET1;
            end else begin
              reject_q <= 1'b1;
            end
          end
          S_GET1: begin
            if (accept1) begin
              prime1_q <= bus.sw;
              reject_q <= 1'b0;
              pair_q   <= 1'b1;
              state_q  <= S_SHOW0;
            end else begin
              reject_q <= 1'b1;
            end
          end
          S_SHOW0: begin
            state_q <= S_SHOW1;
          end
          S_SHOW1: begin
            state_q <= S_GET0;
            pair_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign bus.prime0     = prime0_q;
  assign bus.prime1     = prime1_q;
  assign bus.state      = state_q;
  assign bus.pair_valid = pair_q;
  assign bus.reject     = reject_q;
  assign bus.show_value = show_q;
  assign bus.press_led  = ~db_level;

endmodule
